// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file command controller: default
// datapath/index widths, the command opcode encoding and the controller FSM
// state encoding.
// -----------------------------------------------------------------------------
package regfile_pkg;

   // Default register data width and register index width (4 registers).
   localparam int REGFILE_DATA_W = 32;
   localparam int REGFILE_ADDR_W = 2;

   // Command opcodes as carried on cmd_op.
   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_COPY  = 2'b10,
      OP_ADD   = 2'b11
   } op_e;

   // Controller FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_cmd_ctrl
// Sequences WRITE / READ / COPY / ADD commands against an external register
// file with combinational read ports and a single synchronous write port.
// One command is in flight at a time:
//   IDLE --accept--> WRITE (WRITE op) or READ (READ/COPY/ADD)
//   READ  --> RESP (READ op) or WRITE (COPY/ADD)
//   WRITE --> RESP
//   RESP  --rsp_ready--> IDLE
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_op, cmd_rd,
//   cmd_rs1, cmd_rs2,
//   cmd_data                command fields, captured on acceptance
//   rsp_valid/rsp_ready     response handshake (valid only in RESP)
//   rsp_data1, rsp_data2,
//   rsp_carry               response payload, held stable through RESP
//   RegWrite, WriteReg,
//   WriteData               register-file write port
//   ReadReg1/2, ReadData1/2 register-file read ports
//
// All outputs are decoded from registers; cmd_* and rsp_ready only reach
// state through flops.
// -----------------------------------------------------------------------------
module regfile_cmd_ctrl
   import regfile_pkg::*;
#(
   parameter int DATA_W = REGFILE_DATA_W,
   parameter int ADDR_W = REGFILE_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_data,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data1,
   output logic [DATA_W-1:0] rsp_data2,
   output logic              rsp_carry,

   output logic              RegWrite,
   output logic [ADDR_W-1:0] WriteReg,
   output logic [DATA_W-1:0] WriteData,
   output logic [ADDR_W-1:0] ReadReg1,
   output logic [ADDR_W-1:0] ReadReg2,
   input  logic [DATA_W-1:0] ReadData1,
   input  logic [DATA_W-1:0] ReadData2
);

   // Controller state and captured command.
   state_e            state_q;
   op_e               op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;
   logic [DATA_W-1:0] data_q;

   // Source operands sampled at the end of the READ cycle.
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata2_q;

   // Response payload, loaded on entry to RESP.
   logic [DATA_W-1:0] rsp_data1_q;
   logic [DATA_W-1:0] rsp_data2_q;
   logic              rsp_carry_q;

   // Full-width sum keeps the carry in bit DATA_W.
   logic [DATA_W:0]   sum_full;
   logic [DATA_W-1:0] wdata;

   assign sum_full = {1'b0, rdata1_q} + {1'b0, rdata2_q};

   // Write-port data is selected from captured values only, so it stays
   // stable outside the WRITE cycle.
   always_comb begin
      wdata = data_q;
      case (op_q)
         OP_COPY: wdata = rdata1_q;
         OP_ADD:  wdata = sum_full[DATA_W-1:0];
         default: wdata = data_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_WRITE;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         data_q      <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         rsp_data1_q <= '0;
         rsp_data2_q <= '0;
         rsp_carry_q <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= op_e'(cmd_op);
                  rd_q    <= cmd_rd;
                  rs1_q   <= cmd_rs1;
                  rs2_q   <= cmd_rs2;
                  data_q  <= cmd_data;
                  state_q <= (op_e'(cmd_op) == OP_WRITE) ? ST_WRITE : ST_READ;
               end
            end

            ST_READ: begin
               // Operands are sampled here, before any write of this
               // command, so rd == rs1/rs2 sees pre-write values.
               rdata1_q <= ReadData1;
               rdata2_q <= ReadData2;
               if (op_q == OP_READ) begin
                  rsp_data1_q <= ReadData1;
                  rsp_data2_q <= ReadData2;
                  rsp_carry_q <= 1'b0;
                  state_q     <= ST_RESP;
               end else begin
                  state_q     <= ST_WRITE;
               end
            end

            ST_WRITE: begin
               rsp_data1_q <= wdata;
               rsp_data2_q <= (op_q == OP_ADD) ? rdata2_q : '0;
               rsp_carry_q <= (op_q == OP_ADD) && sum_full[DATA_W];
               state_q     <= ST_RESP;
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data1 = rsp_data1_q;
   assign rsp_data2 = rsp_data2_q;
   assign rsp_carry = rsp_carry_q;

   // Reset asserted during the WRITE cycle must abort the write itself, not
   // just the following cycle, so the enable is qualified by reset.
   assign RegWrite  = (state_q == ST_WRITE) && !reset;
   assign WriteReg  = rd_q;
   assign WriteData = wdata;
   assign ReadReg1  = rs1_q;
   assign ReadReg2  = rs2_q;

endmodule : regfile_cmd_ctrl

// File: doc/regfile_cmd_ctrl.md
REGFILE_CMD_CTRL -- requirements
Module: regfile_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 2, register index width (4 registers).
REQ-003 SHALL have one clock, clk, and reset, reset; reset is synchronous and active-high.
REQ-004 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  2  00 WRITE, 01 READ, 10 COPY, 11 ADD
- cmd_rd  in  ADDR_W  destination register
- cmd_rs1 / cmd_rs2  in  ADDR_W  source registers
- cmd_data  in  DATA_W  write data (WRITE only)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_data1 / rsp_data2  out  DATA_W  response payload
- rsp_carry  out  1  ADD carry-out
- RegWrite  out  1  register-file write enable
- WriteReg  out  ADDR_W  register-file write index
- WriteData  out  DATA_W  register-file write data
- ReadReg1 / ReadReg2  out  ADDR_W  register-file read indices
- ReadData1 / ReadData2  in  DATA_W  register-file combinational read data

Function
REQ-005 SHALL implement FSM states IDLE, READ, WRITE, RESP.
REQ-006 SHALL assert cmd_ready only in IDLE; on acceptance, capture op/rd/rs1/rs2/data into registers.
REQ-007 Transitions on acceptance: WRITE -> WRITE state; READ, COPY, ADD -> READ state.
REQ-008 READ state (one cycle): ReadReg1/2 = captured rs1/rs2; capture ReadData1/2 at cycle end; then READ op -> RESP, COPY/ADD -> WRITE.
REQ-009 WRITE state (one cycle): RegWrite=1, WriteReg=captured rd; WriteData = cmd_data (WRITE), ReadData1 capture (COPY), or sum (ADD); then -> RESP.
REQ-010 ADD: sum = (rs1 + rs2) mod 2^DATA_W; rsp_carry = bit DATA_W of the full sum.
REQ-011 RESP: rsp_valid=1; rsp_data1/rsp_data2/rsp_carry held stable until rsp_ready=1, then -> IDLE.
REQ-012 Payload: READ = {rs1 value, rs2 value}; WRITE = {cmd_data, 0}; COPY = {copied value, 0}; ADD = {sum, rs2 value}; rsp_carry=0 except ADD.
REQ-013 Latency accept-to-rsp_valid: WRITE 2 cycles, READ 2, COPY/ADD 3; minimum issue interval = latency + 1 (IDLE cycle).
REQ-014 RegWrite SHALL be high exactly one cycle per WRITE/COPY/ADD command, never for READ, never in IDLE/RESP regardless of rsp_ready.
REQ-015 COPY/ADD with rd equal to rs1 or rs2 SHALL use pre-write values (read precedes write).
REQ-016 No combinational path from cmd_* or rsp_ready to any output; all outputs decoded from registers.
REQ-017 ReadReg1/2, WriteReg, WriteData SHALL hold captured values outside their active states.

Reset
REQ-018 On reset: state IDLE; cmd_ready=1 after reset deasserts; rsp_valid, RegWrite, rsp_carry = 0; all index/data outputs = 0.
REQ-019 Reset mid-operation SHALL abort: no RegWrite in the cycle after the reset edge, pending response discarded.

Structure
REQ-020 Shared package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, op enum (WRITE/READ/COPY/ADD) and FSM state enum.
REQ-021 Single flat module, no sub-modules; adder inline.

Verification (bench drives DUT against the team's 4x32 register file)
REQ-022 WRITE rd=2 data=0xDEADBEEF, then READ rs1=2 rs2=0 -> RegWrite one pulse, rsp_data1=0xDEADBEEF, rsp_data2=0x00000000.
REQ-023 r1=0xFFFFFFFF, r2=0x00000002, ADD rd=3 -> rsp_data1=0x00000001, rsp_carry=1, subsequent READ rs1=3 returns 0x00000001.
REQ-024 ADD rd=1 rs1=1 rs2=1 with r1=0x00000005 -> r1 becomes 0x0000000A (pre-write values used).
REQ-025 rsp_ready low 5 cycles in RESP -> rsp_valid and payload stable, cmd_ready=0, no additional RegWrite.
REQ-026 Reset asserted while in WRITE state -> RegWrite=0 next cycle, rsp_valid never rises, target register unchanged.
REQ-027 cmd_valid held high with 4 queued commands, rsp_ready=1 -> all accepted in order, issue intervals 3/3/4/4 cycles per REQ-013.
